// File: rtl/unified_mem_arbiter_pkg.sv
// ============================================================================
//  Module   : unified_mem_arbiter_pkg
//  Brief    : Shared pipeline types for the unified instruction/data memory port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package unified_mem_arbiter_pkg;

   // Pipeline-wide memory bus widths; the arbiter's ADDR_W/DATA_W must match.
   localparam int PIPE_ADDR_W = 32;
   localparam int PIPE_DATA_W = 32;
   localparam int PIPE_BE_W   = PIPE_DATA_W / 8;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_REQ  = 2'd1,
      ARB_RSP  = 2'd2
   } arb_state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2
   } mem_owner_e;

   typedef struct packed {
      logic                   we;
      logic [PIPE_BE_W-1:0]   be;
      logic [PIPE_ADDR_W-1:0] addr;
      logic [PIPE_DATA_W-1:0] wdata;
   } mem_req_t;

endpackage

`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
// ============================================================================
//  Module   : unified_mem_arbiter
//  Brief    : Single-outstanding arbiter sharing one memory between IF and MEM.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module unified_mem_arbiter
   import unified_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W        = PIPE_ADDR_W,
   parameter int DATA_W        = PIPE_DATA_W,
   parameter int MAX_DM_STREAK = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                if_req_i,
   input  logic [ADDR_W-1:0]   if_addr_i,
   input  logic                if_kill_i,
   output logic                if_rvalid_o,
   output logic [DATA_W-1:0]   if_rdata_o,
   output logic                stall_if_o,
   input  logic                dm_req_i,
   input  logic                dm_we_i,
   input  logic [DATA_W/8-1:0] dm_be_i,
   input  logic [ADDR_W-1:0]   dm_addr_i,
   input  logic [DATA_W-1:0]   dm_wdata_i,
   output logic                dm_rvalid_o,
   output logic [DATA_W-1:0]   dm_rdata_o,
   output logic                stall_mem_o,
   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic [DATA_W/8-1:0] mem_be_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   input  logic                mem_gnt_i,
   input  logic                mem_rvalid_i,
   input  logic [DATA_W-1:0]   mem_rdata_i,
   output logic                busy_o
);

   localparam int                  c_streak_w   = $clog2(MAX_DM_STREAK + 1);
   localparam logic [c_streak_w-1:0] c_streak_max = c_streak_w'(MAX_DM_STREAK);

   arb_state_e              r_state;
   arb_state_e              w_state_nxt;
   mem_owner_e              r_owner;
   mem_owner_e              w_cur_owner;
   mem_req_t                r_payload;
   mem_req_t                w_if_payload;
   mem_req_t                w_dm_payload;
   mem_req_t                w_drive;
   logic                    r_discard;
   logic [c_streak_w-1:0]   r_streak;

   logic                    w_if_live;
   logic                    w_arb_valid;
   logic                    w_fetch_wins;
   logic                    w_mem_req;
   logic                    w_rsp;
   logic                    w_if_grant;
   logic                    w_dm_grant;

   // ---------------------------------------------------------------------
   // Arbitration: data has priority unless the fetch has been starved
   // ---------------------------------------------------------------------
   assign w_if_live    = if_req_i & ~if_kill_i;
   assign w_arb_valid  = w_if_live | dm_req_i;
   assign w_fetch_wins = w_if_live & (~dm_req_i | (r_streak == c_streak_max));

   assign w_if_payload = '{we: 1'b0, be: '1, addr: if_addr_i, wdata: '0};
   assign w_dm_payload = '{we: dm_we_i, be: dm_be_i, addr: dm_addr_i, wdata: dm_wdata_i};

   assign w_rsp      = (r_state == ARB_RSP) & mem_rvalid_i;
   assign w_if_grant = w_mem_req & mem_gnt_i & (w_cur_owner == OWN_IF);
   assign w_dm_grant = w_mem_req & mem_gnt_i & (w_cur_owner == OWN_DM);

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ARB_IDLE: begin
            if (w_arb_valid) begin
               w_state_nxt = mem_gnt_i ? ARB_RSP : ARB_REQ;
            end
         end
         ARB_REQ: begin
            if (mem_gnt_i) begin
               w_state_nxt = ARB_RSP;
            end
         end
         ARB_RSP: begin
            if (mem_rvalid_i) begin
               w_state_nxt = ARB_IDLE;
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: output logic
   // ---------------------------------------------------------------------
   always_comb begin
      w_mem_req   = 1'b0;
      w_cur_owner = r_owner;
      w_drive     = r_payload;
      case (r_state)
         ARB_IDLE: begin
            w_mem_req   = w_arb_valid;
            w_cur_owner = !w_arb_valid ? OWN_NONE : (w_fetch_wins ? OWN_IF : OWN_DM);
            w_drive     = w_fetch_wins ? w_if_payload : w_dm_payload;
         end
         ARB_REQ: begin
            w_mem_req = 1'b1;
         end
         default: begin
            w_mem_req = 1'b0;
         end
      endcase
   end

   // Every output is forced low while reset is held, even with requests pending.
   assign mem_req_o   = w_mem_req & rst_ni;
   assign mem_we_o    = mem_req_o & w_drive.we;
   assign mem_be_o    = mem_req_o ? w_drive.be    : '0;
   assign mem_addr_o  = mem_req_o ? w_drive.addr  : '0;
   assign mem_wdata_o = mem_req_o ? w_drive.wdata : '0;

   assign if_rvalid_o = rst_ni & w_rsp & (r_owner == OWN_IF) & ~r_discard & ~if_kill_i;
   assign dm_rvalid_o = rst_ni & w_rsp & (r_owner == OWN_DM);
   assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
   assign dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;

   assign stall_if_o  = rst_ni & if_req_i & ~if_rvalid_o & ~if_kill_i;
   assign stall_mem_o = rst_ni & dm_req_i & ~dm_rvalid_o;
   assign busy_o      = (r_state != ARB_IDLE);

   // ---------------------------------------------------------------------
   // Owner and payload latched at arbitration, released on the response
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_owner   <= OWN_NONE;
         r_payload <= '0;
      end else if ((r_state == ARB_IDLE) && w_arb_valid) begin
         r_owner   <= w_cur_owner;
         r_payload <= w_drive;
      end else if (w_rsp) begin
         r_owner   <= OWN_NONE;
      end
   end

   // A killed fetch still completes on the bus; its response is dropped.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_discard <= 1'b0;
      end else if (w_rsp) begin
         r_discard <= 1'b0;
      end else if ((r_state != ARB_IDLE) && (r_owner == OWN_IF) && if_kill_i) begin
         r_discard <= 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_streak <= '0;
      end else if (!if_req_i || w_if_grant) begin
         r_streak <= '0;
      end else if (w_dm_grant && (r_streak != c_streak_max)) begin
         r_streak <= r_streak + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
// ============================================================================
//  Module   : tb_unified_mem_arbiter
//  Brief    : Directed self-checking bench for unified_mem_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_unified_mem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_kill;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        stall_if;
   logic        dm_req;
   logic        dm_we;
   logic [3:0]  dm_be;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_rvalid;
   logic [31:0] dm_rdata;
   logic        stall_mem;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        busy;

   int errors = 0;
   int checks = 0;

   unified_mem_arbiter #(
      .ADDR_W        (32),
      .DATA_W        (32),
      .MAX_DM_STREAK (4)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .if_req_i     (if_req),
      .if_addr_i    (if_addr),
      .if_kill_i    (if_kill),
      .if_rvalid_o  (if_rvalid),
      .if_rdata_o   (if_rdata),
      .stall_if_o   (stall_if),
      .dm_req_i     (dm_req),
      .dm_we_i      (dm_we),
      .dm_be_i      (dm_be),
      .dm_addr_i    (dm_addr),
      .dm_wdata_i   (dm_wdata),
      .dm_rvalid_o  (dm_rvalid),
      .dm_rdata_o   (dm_rdata),
      .stall_mem_o  (stall_mem),
      .mem_req_o    (mem_req),
      .mem_we_o     (mem_we),
      .mem_be_o     (mem_be),
      .mem_addr_o   (mem_addr),
      .mem_wdata_o  (mem_wdata),
      .mem_gnt_i    (mem_gnt),
      .mem_rvalid_i (mem_rvalid),
      .mem_rdata_i  (mem_rdata),
      .busy_o       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Grant order expected while data streams and a fetch waits.
   logic [31:0] starve_addr [6];
   logic        starve_dm   [6];

   initial begin
      starve_addr = '{32'h4000, 32'h4000, 32'h4000, 32'h4000, 32'h0300, 32'h4000};
      starve_dm   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

      rst_n = 1'b0; if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
      dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

      #2;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_if_rvalid", if_rvalid, 0);
      chk("rst_dm_rvalid", dm_rvalid, 0);
      chk("rst_stalls", {stall_if, stall_mem}, 0);
      @(negedge clk); rst_n = 1'b1;

      // Fetch only, immediate grant, response one cycle later
      @(negedge clk); if_req = 1'b1; if_addr = 32'h100; mem_gnt = 1'b1; #1;
      chk("f1_req", mem_req, 1);
      chk("f1_addr", mem_addr, 32'h100);
      chk("f1_we_be", {mem_we, mem_be}, 5'b0_1111);
      chk("f1_stall_c0", stall_if, 1);
      @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00000013; #1;
      chk("f1_rvalid", if_rvalid, 1);
      chk("f1_rdata", if_rdata, 32'h00000013);
      chk("f1_stall_c1", stall_if, 0);
      chk("f1_busy_rsp", busy, 1);
      chk("f1_req_rsp", mem_req, 0);
      @(negedge clk); mem_rvalid = 1'b0; if_req = 1'b0; #1;
      chk("f1_idle", busy, 0);

      // Stray response while idle is ignored
      @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'h1234; #1;
      chk("stray_rvalids", {if_rvalid, dm_rvalid}, 0);
      @(negedge clk); mem_rvalid = 1'b0; #1;
      chk("stray_busy", busy, 0);

      // Simultaneous fetch and store: store first
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h104;
      dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h2000; dm_wdata = 32'hCAFE;
      mem_gnt = 1'b1; #1;
      chk("sim_addr0", mem_addr, 32'h2000);
      chk("sim_we_be", {mem_we, mem_be}, 5'b1_0011);
      chk("sim_wdata", mem_wdata, 32'hCAFE);
      @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0; #1;
      chk("sim_dm_rvalid", dm_rvalid, 1);
      chk("sim_if_rvalid", if_rvalid, 0);
      chk("sim_stalls", {stall_if, stall_mem}, 2'b10);
      @(negedge clk); mem_rvalid = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_gnt = 1'b1; #1;
      chk("sim_addr1", mem_addr, 32'h104);
      chk("sim_fetch_we_be", {mem_we, mem_be}, 5'b0_1111);
      @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11111111; #1;
      chk("sim_if_rdata", {if_rvalid, if_rdata}, {1'b1, 32'h11111111});
      @(negedge clk); mem_rvalid = 1'b0; if_req = 1'b0;

      // Starvation: fetch gets the slot after four data grants
      if_req = 1'b1; if_addr = 32'h300;
      dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h4000;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); mem_gnt = 1'b1; mem_rvalid = 1'b0; #1;
         chk($sformatf("starve_addr%0d", i), mem_addr, starve_addr[i]);
         @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'(i); #1;
         chk($sformatf("starve_owner%0d", i), {dm_rvalid, if_rvalid},
             {starve_dm[i], ~starve_dm[i]});
      end
      @(negedge clk); mem_rvalid = 1'b0; dm_req = 1'b0; if_req = 1'b0;

      // Grant delay with illegally changing address
      @(negedge clk);
      dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'hF; dm_addr = 32'h5000; dm_wdata = 32'hA5A5;
      mem_gnt = 1'b0; #1;
      chk("gd_addr_idle", mem_addr, 32'h5000);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); dm_addr = 32'h6000 + 32'(i); #1;
         chk($sformatf("gd_hold%0d", i), {busy, mem_req, mem_addr}, {2'b11, 32'h5000});
      end
      @(negedge clk); mem_gnt = 1'b1; #1;
      chk("gd_addr_gnt", mem_addr, 32'h5000);
      @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; #1;
      chk("gd_dm_rvalid", dm_rvalid, 1);
      @(negedge clk); mem_rvalid = 1'b0; dm_req = 1'b0; dm_we = 1'b0;

      // Kill after fetch grant: response dropped, next fetch delivered
      @(negedge clk); if_req = 1'b1; if_addr = 32'h180; mem_gnt = 1'b1; #1;
      chk("kill_addr", mem_addr, 32'h180);
      @(negedge clk); mem_gnt = 1'b0; if_kill = 1'b1; #1;
      chk("kill_stall", stall_if, 0);
      @(negedge clk); if_kill = 1'b0; if_addr = 32'h200; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
      chk("kill_drop", {if_rvalid, if_rdata}, 0);
      chk("kill_stall_new", stall_if, 1);
      @(negedge clk); mem_rvalid = 1'b0; mem_gnt = 1'b1; #1;
      chk("kill_next_addr", {mem_req, mem_addr}, {1'b1, 32'h200});
      @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00000293; #1;
      chk("kill_next_data", {if_rvalid, if_rdata}, {1'b1, 32'h00000293});

      // Kill coincident with the response
      @(negedge clk); mem_rvalid = 1'b0; if_addr = 32'h240; mem_gnt = 1'b1; #1;
      chk("kill2_addr", mem_addr, 32'h240);
      @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55; if_kill = 1'b1; #1;
      chk("kill2_drop", {if_rvalid, dm_rvalid}, 0);
      @(negedge clk); mem_rvalid = 1'b0; if_kill = 1'b0; if_req = 1'b0; #1;
      chk("kill2_idle", busy, 0);

      // Asynchronous reset while waiting for a grant
      @(negedge clk); dm_req = 1'b1; dm_addr = 32'h7000; mem_gnt = 1'b0; #1;
      chk("ar_idle", {busy, mem_req}, 2'b01);
      @(negedge clk); #1;
      chk("ar_req", {busy, mem_req, mem_addr}, {2'b11, 32'h7000});
      #1 rst_n = 1'b0;
      #1;
      chk("ar_abort", {busy, mem_req, stall_mem}, 0);
      dm_req = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); #1;
      chk("ar_after", {busy, mem_req}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-ported instruction/data memory between the IF-stage fetch port and the MEM-stage load/store port of the 5-stage pipeline. Sequences one transaction at a time over a req/gnt/rvalid memory handshake and routes each response to its owner. Raises per-stage stall requests consumed next to the hazard unit's load-use stalls. Discards fetch responses killed by a taken branch.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; byte enables are `DATA_W/8` bits.
- `MAX_DM_STREAK`, default 4: maximum consecutive data grants while a fetch is pending (≥1).

- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `if_req_i`  in  1  fetch request; held with `if_addr_i` until `if_rvalid_o` or `if_kill_i`.
- `if_addr_i`  in  ADDR_W  fetch address.
- `if_kill_i`  in  1  branch-taken flush of the fetch in flight.
- `if_rvalid_o`  out  1  fetch data valid, 1 cycle.
- `if_rdata_o`  out  DATA_W  fetch data.
- `stall_if_o`  out  1  `if_req_i & ~if_rvalid_o & ~if_kill_i`.
- `dm_req_i`  in  1  data request; held stable until `dm_rvalid_o`.
- `dm_we_i`  in  1  1 = store.
- `dm_be_i`  in  DATA_W/8  byte enables.
- `dm_addr_i`  in  ADDR_W  data address.
- `dm_wdata_i`  in  DATA_W  store data.
- `dm_rvalid_o`  out  1  load data or store ack, 1 cycle.
- `dm_rdata_o`  out  DATA_W  load data.
- `stall_mem_o`  out  1  `dm_req_i & ~dm_rvalid_o`.
- `mem_req_o`, `mem_we_o`, `mem_be_o`, `mem_addr_o`, `mem_wdata_o`  out  1/1/DATA_W/8/ADDR_W/DATA_W  memory request channel.
- `mem_gnt_i`  in  1  request accepted this cycle.
- `mem_rvalid_i`  in  1  response; exactly one per grant, stores included.
- `mem_rdata_i`  in  DATA_W  response data.
- `busy_o`  out  1  state ≠ IDLE.

## Operation
- FSM states:
  - IDLE: no transaction.
  - REQ: owner latched; waiting for `mem_gnt_i`.
  - RSP: granted; waiting for `mem_rvalid_i`.
- Only one transaction is outstanding at any time.
- IDLE:
  - Arbitrate among `dm_req_i` and `if_req_i & ~if_kill_i`.
  - Data wins by default. Fetch wins if the streak counter equals `MAX_DM_STREAK` and fetch is requesting.
  - Winner's payload drives `mem_*` combinationally with `mem_req_o`=1; owner and payload are latched.
  - Gnt in the same cycle → RSP; otherwise → REQ.
  - Fetch payload is forced to `we`=0 and `be`=all-ones.
- REQ:
  - Drive the latched payload with `mem_req_o`=1 until gnt, then → RSP.
  - A request is never retracted, even if killed.
- RSP:
  - `mem_req_o`=0.
  - On `mem_rvalid_i`: forward `mem_rdata_i` and a valid to the owner in the same cycle (combinational), then → IDLE.
- Kill:
  - `if_kill_i` while the owner is IF in REQ or RSP sets a discard flag. The matching rvalid is then not forwarded (`if_rvalid_o`=0); the flag clears on that rvalid.
  - Kill asserted together with rvalid also suppresses that rvalid.
- Streak counter, saturating at `MAX_DM_STREAK`:
  - Increments on each data grant while `if_req_i`=1.
  - Clears on a fetch grant or whenever `if_req_i`=0.
- A new arbitration is possible in the cycle after a response (IDLE), so back-to-back transactions take 2 cycles minimum.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE; owner NONE; streak 0; discard 0.
- Reset asserted mid-transaction aborts to IDLE; the memory is reset by the same `rst_ni`.
- Minimum latency, req→rvalid_o: 1 cycle (gnt in cycle 0, rvalid in cycle 1).
- `mem_rvalid_i` in IDLE or REQ is a protocol error and is ignored.
- Stall outputs are combinational from inputs and rvalid; the pipeline freezes the requesting stage until its rvalid.

## Structure
- Add to the shared pipeline types package:
  - `arb_state_e` {ARB_IDLE, ARB_REQ, ARB_RSP}.
  - `mem_owner_e` {OWN_NONE, OWN_IF, OWN_DM}.
  - `mem_req_t` packed struct {we, be, addr, wdata}.
- Single module; no sub-module. The streak counter is a local register.

## Test plan
- Fetch only:
  - Stimulus: fetch at 0x100, gnt immediate, rvalid next cycle with 0x00000013.
  - Required: `if_rvalid_o`=1, `if_rdata_o`=0x00000013 at cycle 1; `stall_if_o` low from cycle 1.
- Simultaneous requests:
  - Stimulus: fetch 0x104 and store to 0x2000, `be`=4'b0011.
  - Required: store is issued first with `mem_we_o`=1 and `mem_be_o`=0011; fetch is issued after the store's rvalid.
- Starvation, `MAX_DM_STREAK`=4:
  - Stimulus: `dm_req_i` held continuously with the fetch pending.
  - Required: grants in the order DM,DM,DM,DM,IF,DM…
- Gnt delay:
  - Stimulus: `mem_gnt_i` low for 3 cycles while `dm_addr_i` changes illegally.
  - Required: `mem_addr_o` holds the latched address throughout REQ.
- Kill in RSP:
  - Stimulus: `if_kill_i` pulsed after the fetch gnt.
  - Required: rvalid 0xDEADBEEF is not forwarded; the next fetch at 0x200 returns its own data.
- Async reset in REQ:
  - Stimulus: assert `rst_ni` while in REQ.
  - Required: `mem_req_o`=0 and `busy_o`=0 immediately, before the next clock edge.
